// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer controller: state encoding and
// the short tick period used when simulating.
package countdown_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SIM_TICK_DIV = 4;

endpackage : countdown_pkg

// File: rtl/tick_prescaler.sv
// Enable-gated, clearable modulo-TICK_DIV counter. tick_o marks the last
// cycle of each period, on which the count wraps back to zero.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int PW       = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/countdown_ctrl.sv
// Sequencer for a cascade of BCD down-counter digits: start/pause/clear
// handling, count tick, borrow-chain enables and terminal-zero stop.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int PW       = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic [DIGITS-1:0] dec_in,
    output logic [DIGITS-1:0] cnt_en,
    output logic              dig_load,
    output logic              running,
    output logic              done,
    output logic              done_pulse
);

    state_t state_q;
    state_t state_d;
    logic   dig_load_q;
    logic   dig_load_d;
    logic   done_pulse_q;
    logic   done_pulse_d;
    logic   load_req;
    logic   tick;
    logic   allzero;
    logic   pause_eff;
    logic   count_tick;

    assign allzero   = &dec_in;
    // start outranks pause, so a coincident start masks the pause toggle
    assign pause_eff = pause & ~start;

    // Holding the prescaler clear outside RUN makes every entry to RUN
    // (including resume) begin a fresh full period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PW       (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == S_RUN),
        .clr_i  (state_q != S_RUN),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dig_load_q   <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_load_q   <= dig_load_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_req     = 1'b0;
        done_pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    load_req = 1'b1;
                end else if (start) begin
                    if (allzero) begin
                        state_d      = S_DONE;
                        done_pulse_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    load_req = 1'b1;
                end else if (pause_eff) begin
                    state_d = S_PAUSE;
                end else if (tick && allzero) begin
                    state_d      = S_DONE;
                    done_pulse_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    load_req = 1'b1;
                end else if (start || pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    load_req = 1'b1;
                end else if (start) begin
                    state_d  = S_RUN;
                    load_req = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        dig_load_d = load_req & ~dig_load_q;
    end

    always_comb begin
        running    = (state_q == S_RUN);
        done       = (state_q == S_DONE);
        dig_load   = dig_load_q;
        done_pulse = done_pulse_q;
    end

    // tick already implies RUN; a leaving pulse on the tick cycle suppresses counting
    assign count_tick = tick & ~allzero & ~clear & ~pause_eff;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_en
            if (gi == 0) begin : g_lsd
                assign cnt_en[gi] = count_tick;
            end else begin : g_upper
                assign cnt_en[gi] = count_tick & (&dec_in[gi-1:0]);
            end
        end
    endgenerate

endmodule : countdown_ctrl

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl driving four behavioural BCD down-counter
// digits (reload = rst | dig_load, init value selectable).
module tb_countdown_ctrl;
    import countdown_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  dec_in;
    logic [3:0]  cnt_en;
    logic        dig_load;
    logic        running;
    logic        done;
    logic        done_pulse;

    logic [3:0]  dig [4];
    logic [15:0] init_val = 16'h0100;
    logic [15:0] digs;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    countdown_ctrl #(
        .DIGITS   (4),
        .TICK_DIV (SIM_TICK_DIV),
        .PW       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .dec_in     (dec_in),
        .cnt_en     (cnt_en),
        .dig_load   (dig_load),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || dig_load)
                dig[i] <= init_val[4*i +: 4];
            else if (cnt_en[i])
                dig[i] <= (dig[i] == 4'd0) ? 4'd9 : dig[i] - 4'd1;
        end
    end

    always_comb begin
        dec_in = '0;
        for (int i = 0; i < 4; i++) dec_in[i] = (dig[i] == 4'd0);
    end

    assign digs = {dig[3], dig[2], dig[1], dig[0]};

    typedef struct {
        logic        st;
        logic        pa;
        logic        cl;
        logic [3:0]  en;
        logic        ld;
        logic        rn;
        logic        dn;
        logic        dp;
        logic [15:0] dg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, pa, cl, input logic [3:0] en,
                                input logic ld, rn, dn, dp, input logic [15:0] dg);
        vec_t v;
        v.st = st; v.pa = pa; v.cl = cl; v.en = en;
        v.ld = ld; v.rn = rn; v.dn = dn; v.dp = dp; v.dg = dg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c);
        start = s; pause = p; clear = c;
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int  n;
        bit  wrap_bad;
        bit  got_done;

        // start pulse to first tick = 4 cycles; tick enables 0111 from 0100
        tbl.push_back(mk(0,0,0, 4'b0000, 0,0,0,0, 16'h0100));
        tbl.push_back(mk(1,0,0, 4'b0000, 0,1,0,0, 16'h0100));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0100));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0100));
        tbl.push_back(mk(0,0,0, 4'b0111, 0,1,0,0, 16'h0100));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0099));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0099));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0099));
        tbl.push_back(mk(0,0,0, 4'b0001, 0,1,0,0, 16'h0099));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0098));
        tbl.push_back(mk(0,1,0, 4'b0000, 0,0,0,0, 16'h0098));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,0,0,0, 16'h0098));
        tbl.push_back(mk(0,1,0, 4'b0000, 0,1,0,0, 16'h0098));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0098));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0098));
        tbl.push_back(mk(0,0,0, 4'b0001, 0,1,0,0, 16'h0098));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,1,0,0, 16'h0097));
        tbl.push_back(mk(1,1,1, 4'b0000, 1,0,0,0, 16'h0097));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,0,0,0, 16'h0100));
        tbl.push_back(mk(0,0,0, 4'b0000, 0,0,0,0, 16'h0100));

        // reset state
        @(posedge clk);
        #1;
        chk("reset.outs", {cnt_en, dig_load, running, done, done_pulse}, 32'h0);
        chk("reset.digits", digs, 16'h0100);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].pa, tbl[i].cl);
            chk($sformatf("v%0d.cnt_en", i), cnt_en, tbl[i].en);
            chk($sformatf("v%0d.dig_load", i), dig_load, tbl[i].ld);
            chk($sformatf("v%0d.running", i), running, tbl[i].rn);
            chk($sformatf("v%0d.done", i), done, tbl[i].dn);
            chk($sformatf("v%0d.done_pulse", i), done_pulse, tbl[i].dp);
            chk($sformatf("v%0d.digits", i), digs, tbl[i].dg);
            $display("vec %0d: st=%b pa=%b cl=%b -> cnt_en=%b ld=%b run=%b done=%b dp=%b dig=%h",
                     i, tbl[i].st, tbl[i].pa, tbl[i].cl, cnt_en, dig_load, running, done,
                     done_pulse, digs);
        end

        // long pause: nothing moves for 50 cycles, resume gives a full period
        step(1, 0, 0);
        chk("pause.pre_running", running, 1'b1);
        step(0, 1, 0);
        for (int i = 0; i < 50; i++) begin
            chk($sformatf("pause.hold%0d", i), {running, cnt_en}, 5'b0);
            step(0, 0, 0);
        end
        chk("pause.digits", digs, 16'h0100);
        step(0, 1, 0);
        chk("pause.resumed", running, 1'b1);
        n = 1;
        while (cnt_en == 4'b0 && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("pause.tick_latency", n, 4);
        chk("pause.tick_en", cnt_en, 4'b0111);
        $display("seq pause: resume tick after %0d cycles", n);

        // terminal stop: run to zero, no enables at zero, single done_pulse
        wrap_bad = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            step(0, 0, 0);
            if (digs == 16'h0000 && cnt_en != 4'b0) wrap_bad = 1'b1;
            if (done_pulse) got_done = 1'b1;
        end
        chk("term.done_pulse_seen", got_done, 1'b1);
        chk("term.no_enable_at_zero", wrap_bad, 1'b0);
        chk("term.state", {running, done, cnt_en}, 6'b010000);
        chk("term.digits", digs, 16'h0000);
        step(0, 0, 0);
        chk("term.pulse_once", {done_pulse, done}, 2'b01);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("term.no_wrap", digs, 16'h0000);
        chk("term.still_done", done, 1'b1);
        $display("seq terminal: digits=%h done=%b", digs, done);

        // restart from DONE: reload, then first tick 4 cycles after start
        step(1, 0, 0);
        chk("restart.load", {dig_load, running, done}, 3'b110);
        step(0, 0, 0);
        chk("restart.load_once", dig_load, 1'b0);
        chk("restart.reloaded", digs, 16'h0100);
        n = 2;
        while (cnt_en == 4'b0 && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("restart.tick_latency", n, 4);
        step(0, 0, 0);
        chk("restart.first_dec", digs, 16'h0099);
        $display("seq restart: digits=%h after first tick", digs);

        // start with all-zero init goes straight to DONE
        init_val = 16'h0000;
        step(0, 0, 1);
        chk("zero.clear", {dig_load, running}, 2'b10);
        step(0, 0, 0);
        chk("zero.digits", digs, 16'h0000);
        step(1, 0, 0);
        chk("zero.done", {running, done, done_pulse, cnt_en}, 7'b0110000);
        step(0, 0, 0);
        chk("zero.pulse_once", {done, done_pulse}, 2'b10);
        $display("seq zero-start: done=%b", done);

        // asynchronous reset mid-run
        init_val = 16'h0100;
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("arst.pre_running", running, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.outs", {cnt_en, dig_load, running, done, done_pulse}, 32'h0);
        chk("arst.digits", digs, 16'h0100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0);
        chk("arst.idle", {running, done}, 2'b00);
        $display("seq async-reset: running=%b", running);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_countdown_ctrl

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for a cascade of DIGITS BCD down-counter digits. These form a countdown timer, for example MM:SS.
- Generates the count tick, the per-digit count enables and the borrow chain. Digit i counts only when every lower digit is at 0.
- Handles start, pause and clear button pulses, and a terminal-zero stop, so the cascade never wraps from 0 to 9.
- Sits between the debounced, one-pulsed buttons and the digit counters. Its outputs also feed the display and alarm logic.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (range 1..8).
- TICK_DIV, 100000000, clk cycles per count tick (at least 2). Use 4 in simulation.
- PW, 27, prescaler width. Must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: start, resume, or restart after done.
- pause  in  1  one-cycle pulse: toggles between RUN and PAUSE.
- clear  in  1  one-cycle pulse: reload the digits and return to IDLE.
- dec_in  in  DIGITS  per-digit "digit == 0" flags from the counters. Bit 0 is the least significant digit.
- cnt_en  out  DIGITS  per-digit count enable. Each counter uses stop = ~cnt_en[i].
- dig_load  out  1  registered one-cycle pulse. Integration ORs it into each counter's reload (rst/init) input.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- done_pulse  out  1  registered one-cycle pulse on entry to DONE.

Behaviour:
- Clock and reset: single clock domain; all state changes on the posedge of clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, prescaler=0, dig_load=0, done_pulse=0. The derived outputs are therefore cnt_en=0, running=0, done=0.
- States: IDLE, RUN, PAUSE, DONE, encoded in 2 bits.
- Input priority when several pulses coincide: clear > start > pause.
- allzero is the AND of all bits of dec_in.

State transitions:
- IDLE, on start: go to RUN if allzero=0, otherwise go to DONE (asserting done_pulse).
- IDLE, on clear: pulse dig_load and stay in IDLE.
- RUN, on clear: go to IDLE and pulse dig_load.
- RUN, on pause: go to PAUSE.
- RUN, on a tick cycle with allzero=1: go to DONE and assert done_pulse for one cycle. No enables are raised on that cycle.
- PAUSE, on start or pause: go back to RUN.
- PAUSE, on clear: go to IDLE and pulse dig_load.
- DONE, on clear: go to IDLE and pulse dig_load.
- DONE, on start: pulse dig_load and go to RUN. The reload lands before the next tick, so counting resumes from the init values.

Prescaler:
- Counts only in RUN, and is cleared to 0 on every entry to RUN.
- tick = (state==RUN) and (prescaler==TICK_DIV-1). The prescaler wraps to 0 on the tick cycle.
- The first tick after entering RUN occurs exactly TICK_DIV cycles later.
- PAUSE freezes nothing. The prescaler is cleared on resume, so the partial period is discarded.

Enables (combinational from registered state, prescaler and dec_in):
- cnt_en[0] = tick & ~allzero.
- cnt_en[i] = cnt_en[0] & (dec_in[0] & ... & dec_in[i-1]) for i >= 1.
- Therefore, outside RUN, and on the terminal tick, cnt_en = 0.
- A pause or clear arriving on a tick cycle still takes priority: cnt_en = 0 on that cycle.

Output signals:
- running = (state==RUN); done = (state==DONE).
- dig_load is high exactly one cycle after the clear or start edge that requests it, and never two cycles in a row.

Reset mid-run: abort immediately to IDLE with all outputs at their reset values. The counters are reset by the same rst.

Decomposition:
- Shared package countdown_pkg holds the state encoding constants S_IDLE=0, S_RUN=1, S_PAUSE=2, S_DONE=3. It also holds the simulation TICK_DIV constant.
- One natural sub-module: tick_prescaler (an enable-gated, clearable modulo-TICK_DIV counter with a tick output). The FSM and enable chain stay in the top module.

Test Plan:
Bench setup: TICK_DIV=4 and DIGITS=4. Instantiate four BCD down-counter digits with stop=~cnt_en[i], reload = rst | dig_load, and init d3..d0 = 0,1,0,0.
- Borrow chain: rst, then start. The first tick raises cnt_en=4'b0111 for exactly one cycle and the digits read 0,0,9,9. Four cycles later cnt_en=4'b0001 and the digits read 0,0,9,8.
- Terminal stop: run to 0,0,0,0. On the next tick cnt_en=0, done_pulse=1 for one cycle, then done=1. The digits stay 0,0,0,0 indefinitely, with no wrap to 9.
- Pause: pause in RUN gives running=0 and no enables for 50 cycles. A second pause resumes; the first tick arrives exactly 4 cycles after resuming.
- Clear priority: clear, start and pause asserted in the same cycle during RUN go to IDLE. dig_load=1 on the next cycle only, the digits return to 0,1,0,0, and cnt_en=0.
- Restart from DONE: start in DONE pulses dig_load once and enters RUN. The first tick, 4 cycles after entering RUN, decrements 0,1,0,0 to 0,0,9,9.
- Edge cases: start in IDLE with init 0,0,0,0 goes straight to DONE with done_pulse=1. Asserting rst mid-RUN gives state IDLE and all outputs 0 asynchronously, before the next clk edge.
